wb_stage: RTL and testbench

//  Final (write-back) pipeline stage, directly downstream of the memory stage.

---
 rtl/wb_stage_pkg.sv | 45 ++++
 rtl/wb_bus_unpack.sv | 42 ++++
 rtl/wb_stage.sv | 117 +++++++++++
 tb/tb_wb_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Write-back stage shared constants: bus widths, MEM->WB field offsets,
// exception codes and CSR numbers.
package wb_stage_pkg;

  localparam int BUS_W = 232;
  localparam int FWD_W = 54;

  // MEM->WB field LSB offsets
  localparam int OFF_ECODE    = 0;
  localparam int OFF_ESUBCODE = 6;
  localparam int OFF_EX       = 15;
  localparam int OFF_BADADDR  = 16;
  localparam int OFF_SYSCALL  = 48;
  localparam int OFF_ERTN     = 49;
  localparam int OFF_CSRWVAL  = 50;
  localparam int OFF_CSRWMASK = 82;
  localparam int OFF_CSRNUM   = 114;
  localparam int OFF_CSRRE    = 128;
  localparam int OFF_CSRWE    = 129;
  localparam int OFF_DEST     = 130;
  localparam int OFF_RESULT   = 135;
  localparam int OFF_INST     = 167;
  localparam int OFF_PC       = 199;
  localparam int OFF_GRWE     = 231;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_PRMD   = 14'h0001;
  localparam logic [13:0] CSR_ECFG   = 14'h0004;
  localparam logic [13:0] CSR_ESTAT  = 14'h0005;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_BADV   = 14'h0007;
  localparam logic [13:0] CSR_EENTRY = 14'h000c;
  localparam logic [13:0] CSR_SAVE0  = 14'h0030;

endpackage

// File: rtl/wb_bus_unpack.sv
// Splits the latched MEM->WB bus into named fields.
// In: wb_bus; Out: one port per field.
module wb_bus_unpack
  import wb_stage_pkg::*;
(
  input  logic [231:0] wb_bus,
  output logic         gr_we,
  output logic [31:0]  pc,
  output logic [31:0]  inst,
  output logic [31:0]  result,
  output logic [4:0]   dest,
  output logic         csr_we,
  output logic         csr_re,
  output logic [13:0]  csr_num,
  output logic [31:0]  csr_wmask,
  output logic [31:0]  csr_wvalue,
  output logic         ertn,
  output logic         syscall,
  output logic [31:0]  bad_addr,
  output logic         ex,
  output logic [8:0]   esubcode,
  output logic [5:0]   ecode
);

  assign gr_we      = wb_bus[OFF_GRWE];
  assign pc         = wb_bus[OFF_PC +: 32];
  assign inst       = wb_bus[OFF_INST +: 32];
  assign result     = wb_bus[OFF_RESULT +: 32];
  assign dest       = wb_bus[OFF_DEST +: 5];
  assign csr_we     = wb_bus[OFF_CSRWE];
  assign csr_re     = wb_bus[OFF_CSRRE];
  assign csr_num    = wb_bus[OFF_CSRNUM +: 14];
  assign csr_wmask  = wb_bus[OFF_CSRWMASK +: 32];
  assign csr_wvalue = wb_bus[OFF_CSRWVAL +: 32];
  assign ertn       = wb_bus[OFF_ERTN];
  assign syscall    = wb_bus[OFF_SYSCALL];
  assign bad_addr   = wb_bus[OFF_BADADDR +: 32];
  assign ex         = wb_bus[OFF_EX];
  assign esubcode   = wb_bus[OFF_ESUBCODE +: 9];
  assign ecode      = wb_bus[OFF_ECODE +: 6];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches MEM->WB bus, commits GPR/CSR writes,
// exceptions and ertn, drives trace and the WB->ID forwarding bus.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_wb_valid,
  output logic         wb_allowin,
  input  logic [231:0] mem_wb_bus,
  input  logic [31:0]  csr_rvalue,
  output logic [13:0]  csr_num,
  output logic         csr_we,
  output logic [31:0]  csr_wmask,
  output logic [31:0]  csr_wvalue,
  output logic         wb_ex,
  output logic         ertn_flush,
  output logic [5:0]   wb_ecode,
  output logic [8:0]   wb_esubcode,
  output logic [31:0]  wb_pc,
  output logic [31:0]  wb_vaddr,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [31:0]  rf_wdata,
  output logic [53:0]  wb_id_bus,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_we,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);

  logic         wb_valid;
  logic [231:0] wb_bus_r;
  logic         wb_ready_go;
  logic         flush;
  logic         kill;
  logic         wb_bypass;

  logic         f_gr_we;
  logic [31:0]  f_pc;
  logic [31:0]  f_inst;
  logic [31:0]  f_result;
  logic [4:0]   f_dest;
  logic         f_csr_we;
  logic         f_csr_re;
  logic         f_ertn;
  logic         f_syscall;
  logic         f_ex;

  wb_bus_unpack u_unpack (
    .wb_bus     (wb_bus_r),
    .gr_we      (f_gr_we),
    .pc         (f_pc),
    .inst       (f_inst),
    .result     (f_result),
    .dest       (f_dest),
    .csr_we     (f_csr_we),
    .csr_re     (f_csr_re),
    .csr_num    (csr_num),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .ertn       (f_ertn),
    .syscall    (f_syscall),
    .bad_addr   (wb_vaddr),
    .ex         (f_ex),
    .esubcode   (wb_esubcode),
    .ecode      (wb_ecode)
  );

  // inst/syscall travel for trace completeness only
  logic unused_fields;
  assign unused_fields = ^{f_inst, f_syscall};

  assign wb_ready_go = 1'b1;
  assign wb_allowin  = ~wb_valid | wb_ready_go;

  // ex is also set upstream for ertn; ertn wins
  assign ertn_flush = wb_valid & f_ertn;
  assign wb_ex      = wb_valid & f_ex & ~f_ertn;
  assign flush      = wb_ex | ertn_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_bus_r <= '0;
    end else begin
      if (flush)
        wb_valid <= 1'b0;
      else if (wb_allowin)
        wb_valid <= mem_wb_valid;
      if (mem_wb_valid & wb_allowin & ~flush)
        wb_bus_r <= mem_wb_bus;
    end
  end

  // reset also blocks the write of the instruction being discarded
  assign kill = ~wb_valid | f_ex | f_ertn | reset;

  assign rf_we    = ~kill & f_gr_we & (f_dest != 5'd0);
  assign csr_we   = ~kill & f_csr_we;
  assign rf_waddr = f_dest;
  assign rf_wdata = f_csr_re ? csr_rvalue : f_result;
  assign wb_pc    = f_pc;

  // no forwarding from a faulting instruction; stale bus after a
  // flush must not raise a CSR interlock either
  assign wb_bypass = wb_valid & f_gr_we & ~f_ex;
  assign wb_id_bus = {wb_bypass, f_dest, rf_wdata,
                      wb_valid & f_gr_we, wb_valid & f_csr_re,
                      csr_num};

  assign debug_wb_pc       = f_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = f_dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Hand-computed vectors, immediate assertions at each check.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_wb_valid;
  logic         wb_allowin;
  logic [231:0] mem_wb_bus;
  logic [31:0]  csr_rvalue;
  logic [13:0]  csr_num;
  logic         csr_we;
  logic [31:0]  csr_wmask;
  logic [31:0]  csr_wvalue;
  logic         wb_ex;
  logic         ertn_flush;
  logic [5:0]   wb_ecode;
  logic [8:0]   wb_esubcode;
  logic [31:0]  wb_pc;
  logic [31:0]  wb_vaddr;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [53:0]  wb_id_bus;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_we;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .mem_wb_valid      (mem_wb_valid),
    .wb_allowin        (wb_allowin),
    .mem_wb_bus        (mem_wb_bus),
    .csr_rvalue        (csr_rvalue),
    .csr_num           (csr_num),
    .csr_we            (csr_we),
    .csr_wmask         (csr_wmask),
    .csr_wvalue        (csr_wvalue),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .wb_ecode          (wb_ecode),
    .wb_esubcode       (wb_esubcode),
    .wb_pc             (wb_pc),
    .wb_vaddr          (wb_vaddr),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .wb_id_bus         (wb_id_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fields in MSB->LSB order of the MEM->WB bus
  function automatic logic [231:0] mk(
    input logic        gr_we,
    input logic [31:0] pc,
    input logic [31:0] result,
    input logic [4:0]  dest,
    input logic        cwe,
    input logic        cre,
    input logic [13:0] cnum,
    input logic [31:0] wmask,
    input logic [31:0] wval,
    input logic        ertn,
    input logic        sys,
    input logic [31:0] badv,
    input logic        ex,
    input logic [8:0]  esub,
    input logic [5:0]  ecode);
    logic [31:0] inst;
    inst = pc ^ 32'h0280_0000;
    return {gr_we, pc, inst, result, dest, cwe, cre, cnum,
            wmask, wval, ertn, sys, badv, ex, esub, ecode};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    mem_wb_valid = 1'b1;
    csr_rvalue   = 32'h0;
    mem_wb_bus   = mk(1'b1, 32'h1c00_0000, 32'h1, 5'd1, 1'b1,
                      1'b0, 14'h1, 32'h1, 32'h1, 1'b0, 1'b0,
                      32'h0, 1'b0, 9'h0, 6'h0);

    // 1: reset held 3 cycles with valid input
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rf_we", {63'b0, rf_we}, 64'd0);
      chk("rst_csr_we", {63'b0, csr_we}, 64'd0);
      chk("rst_pc", {32'b0, debug_wb_pc}, 64'd0);
      chk("rst_idbus", {10'b0, wb_id_bus}, 64'd0);
    end
    chk("rst_ex", {62'b0, wb_ex, ertn_flush}, 64'd0);
    chk("allowin", {63'b0, wb_allowin}, 64'd1);

    // 2: add r5
    reset = 1'b0;
    mem_wb_bus = mk(1'b1, 32'h1c00_0000, 32'h1234_5678, 5'd5,
                    1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                    32'h0, 1'b0, 9'h0, 6'h0);
    tick();
    chk("add_rf_we", {63'b0, rf_we}, 64'd1);
    chk("add_waddr", {59'b0, rf_waddr}, 64'd5);
    chk("add_wdata", {32'b0, rf_wdata}, 64'h1234_5678);
    chk("add_dbg_we", {60'b0, debug_wb_rf_we}, 64'hf);
    chk("add_dbg_pc", {32'b0, debug_wb_pc}, 64'h1c00_0000);
    chk("add_idbus", {10'b0, wb_id_bus},
        {10'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, 14'h0});

    // 3: csrrd r6 <- CRMD
    mem_wb_bus = mk(1'b1, 32'h1c00_0004, 32'h0, 5'd6, 1'b0,
                    1'b1, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                    32'h0, 1'b0, 9'h0, 6'h0);
    csr_rvalue = 32'hB;
    tick();
    chk("csrrd_wdata", {32'b0, rf_wdata}, 64'hB);
    chk("csrrd_idbus", {62'b0, wb_id_bus[15:14]}, 64'd3);
    chk("csrrd_csr_we", {63'b0, csr_we}, 64'd0);

    // csrwr r4 <-> SAVE0
    mem_wb_bus = mk(1'b1, 32'h1c00_0008, 32'h0, 5'd4, 1'b1,
                    1'b1, 14'h30, 32'hffff_0000, 32'hdead_beef,
                    1'b0, 1'b0, 32'h0, 1'b0, 9'h0, 6'h0);
    csr_rvalue = 32'h55;
    tick();
    chk("csrwr_we", {63'b0, csr_we}, 64'd1);
    chk("csrwr_num", {50'b0, csr_num}, 64'h30);
    chk("csrwr_mask", {32'b0, csr_wmask}, 64'hffff_0000);
    chk("csrwr_val", {32'b0, csr_wvalue}, 64'hdead_beef);
    chk("csrwr_wdata", {32'b0, rf_wdata}, 64'h55);

    // 4: syscall, followed by a valid instruction that must drop
    mem_wb_bus = mk(1'b1, 32'h1c00_0010, 32'h77, 5'd3, 1'b1,
                    1'b0, 14'h1, 32'h1, 32'h1, 1'b0, 1'b1,
                    32'h1c00_0010, 1'b1, 9'h0, 6'hB);
    tick();
    mem_wb_bus = mk(1'b1, 32'h1c00_0014, 32'h99, 5'd7, 1'b0,
                    1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                    32'h0, 1'b0, 9'h0, 6'h0);
    chk("sys_ex", {63'b0, wb_ex}, 64'd1);
    chk("sys_ertn", {63'b0, ertn_flush}, 64'd0);
    chk("sys_ecode", {58'b0, wb_ecode}, 64'hB);
    chk("sys_pc", {32'b0, wb_pc}, 64'h1c00_0010);
    chk("sys_vaddr", {32'b0, wb_vaddr}, 64'h1c00_0010);
    chk("sys_rf_we", {63'b0, rf_we}, 64'd1 - 64'd1);
    chk("sys_csr_we", {63'b0, csr_we}, 64'd0);
    chk("sys_bypass", {63'b0, wb_id_bus[53]}, 64'd0);
    tick();
    mem_wb_valid = 1'b0;
    chk("sys_next_ex", {63'b0, wb_ex}, 64'd0);
    chk("sys_next_rf", {63'b0, rf_we}, 64'd0);
    chk("sys_next_dbg", {60'b0, debug_wb_rf_we}, 64'd0);
    tick();
    chk("sys_idle_rf", {63'b0, rf_we}, 64'd0);

    // 5: ertn (ex also set upstream)
    mem_wb_valid = 1'b1;
    mem_wb_bus = mk(1'b0, 32'h1c00_0020, 32'h0, 5'd0, 1'b1,
                    1'b0, 14'h1, 32'hf, 32'h3, 1'b1, 1'b0,
                    32'h0, 1'b1, 9'h0, 6'hE);
    tick();
    mem_wb_bus = mk(1'b1, 32'h1c00_0024, 32'h5, 5'd9, 1'b0,
                    1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                    32'h0, 1'b0, 9'h0, 6'h0);
    chk("ertn_flush", {63'b0, ertn_flush}, 64'd1);
    chk("ertn_ex", {63'b0, wb_ex}, 64'd0);
    chk("ertn_csr_we", {63'b0, csr_we}, 64'd0);
    tick();
    chk("ertn_next_fl", {63'b0, ertn_flush}, 64'd0);
    chk("ertn_next_rf", {63'b0, rf_we}, 64'd0);

    // 6: back-to-back r1..r8, then dest 0
    for (int i = 1; i <= 8; i++) begin
      mem_wb_bus = mk(1'b1, 32'h1c00_0100 + 32'(i * 4),
                      32'(i * 32'h1111), 5'(i), 1'b0, 1'b0,
                      14'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                      1'b0, 9'h0, 6'h0);
      tick();
      chk("b2b_we", {63'b0, rf_we}, 64'd1);
      chk("b2b_addr", {59'b0, rf_waddr}, 64'(i));
      chk("b2b_data", {32'b0, rf_wdata}, 64'(i * 32'h1111));
    end
    mem_wb_bus = mk(1'b1, 32'h1c00_0200, 32'habcd, 5'd0, 1'b0,
                    1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                    32'h0, 1'b0, 9'h0, 6'h0);
    tick();
    chk("r0_we", {63'b0, rf_we}, 64'd0);
    chk("r0_dbg_pc", {32'b0, debug_wb_pc}, 64'h1c00_0200);

    // reset mid-instruction: csr+gpr write in WB, reset asserted
    mem_wb_bus = mk(1'b1, 32'h1c00_0300, 32'h42, 5'd10, 1'b1,
                    1'b0, 14'h30, 32'h1, 32'h1, 1'b0, 1'b0,
                    32'h0, 1'b0, 9'h0, 6'h0);
    tick();
    chk("pre_rst_we", {62'b0, rf_we, csr_we}, 64'd3);
    reset = 1'b1;
    #1;
    chk("rst_cyc_we", {62'b0, rf_we, csr_we}, 64'd0);
    tick();
    reset = 1'b0;
    mem_wb_valid = 1'b0;
    chk("post_rst_we", {62'b0, rf_we, csr_we}, 64'd0);
    chk("post_rst_pc", {32'b0, debug_wb_pc}, 64'd0);
    tick();
    chk("idle_we", {62'b0, rf_we, csr_we}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
